// File: rtl/yc_cfg_sched.sv
// Encoder configuration scheduler: software writes shadow registers and commits them,
// and the active values switch over only on the next frame boundary. Also measures line length.
module yc_cfg_sched #(
   parameter logic [39:0] DEF_PHASE_INC = 40'd78715011372,
   parameter logic        DEF_PAL_EN    = 1'b0,
   parameter logic [26:0] DEF_CB_RANGE  = 27'd42189040,
   parameter int          TIMEOUT_W     = 22
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cfg_wr,
   input  logic [1:0]  cfg_addr,
   input  logic [31:0] cfg_wdata,
   output logic        cfg_ready,
   input  logic        hsync,
   input  logic        vsync,
   output logic [39:0] phase_inc,
   output logic        pal_en,
   output logic [26:0] colorburst_range,
   output logic        cfg_pending,
   output logic        cfg_err,
   output logic [11:0] line_len
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_APPLY = 2'd2
   } state_t;

   state_t               state_reg, state_next;
   logic [39:0]          sh_phase_reg;
   logic                 sh_pal_reg;
   logic [26:0]          sh_cb_reg;
   logic                 vsync_q_reg, hsync_q_reg;
   logic [TIMEOUT_W-1:0] wd_reg;
   logic [11:0]          line_cnt_reg;

   logic       cmd_wr, cmd_abort, cmd_commit;
   logic       vs_rise, hs_rise, wd_done;
   logic [9:0] sh_end;
   logic       sh_valid;
   logic       sh_wr, do_accept, do_reject, do_reload, do_apply;
   logic [11:0] line_inc;

   // Command register is always writable, so its decode does not need cfg_ready.
   assign cmd_wr     = cfg_wr && (cfg_addr == 2'd3);
   assign cmd_abort  = cmd_wr && cfg_wdata[1];
   assign cmd_commit = cmd_wr && cfg_wdata[0] && !cfg_wdata[1];
   assign vs_rise    = vsync && !vsync_q_reg;
   assign hs_rise    = hsync && !hsync_q_reg;
   assign wd_done    = &wd_reg;

   // A 10-bit end field can never exceed 1023, so only the ordering needs checking.
   assign sh_end   = sh_pal_reg ? sh_cb_reg[9:0] : sh_cb_reg[19:10];
   assign sh_valid = ({3'b000, sh_cb_reg[26:20]} < sh_end);

   assign line_inc = (line_cnt_reg == 12'hFFF) ? 12'hFFF : line_cnt_reg + 12'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (cmd_commit && sh_valid) state_next = ST_ARMED;
         end
         ST_ARMED: begin
            if (cmd_abort)               state_next = ST_IDLE;
            else if (vs_rise || wd_done) state_next = ST_APPLY;
         end
         ST_APPLY: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      cfg_ready = (state_reg == ST_IDLE) || (cfg_addr == 2'd3);
      sh_wr     = 1'b0;
      do_accept = 1'b0;
      do_reject = 1'b0;
      do_reload = 1'b0;
      do_apply  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            sh_wr     = cfg_wr && (cfg_addr != 2'd3);
            do_reload = cmd_abort;
            do_accept = cmd_commit && sh_valid;
            do_reject = cmd_commit && !sh_valid;
         end
         ST_ARMED: do_reload = cmd_abort;
         ST_APPLY: do_apply  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_phase_reg <= DEF_PHASE_INC;
         sh_pal_reg   <= DEF_PAL_EN;
         sh_cb_reg    <= DEF_CB_RANGE;
      end else if (do_reload) begin
         sh_phase_reg <= phase_inc;
         sh_pal_reg   <= pal_en;
         sh_cb_reg    <= colorburst_range;
      end else if (sh_wr) begin
         case (cfg_addr)
            2'd0: sh_phase_reg[31:0] <= cfg_wdata;
            2'd1: begin
               sh_phase_reg[39:32] <= cfg_wdata[7:0];
               sh_pal_reg          <= cfg_wdata[8];
            end
            2'd2: sh_cb_reg <= cfg_wdata[26:0];
            default: ;
         endcase
      end
   end

   // All active fields switch together so the encoder never sees a mixed configuration.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_inc        <= DEF_PHASE_INC;
         pal_en           <= DEF_PAL_EN;
         colorburst_range <= DEF_CB_RANGE;
      end else if (do_apply) begin
         phase_inc        <= sh_phase_reg;
         pal_en           <= sh_pal_reg;
         colorburst_range <= sh_cb_reg;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cfg_pending <= 1'b0;
         cfg_err     <= 1'b0;
         wd_reg      <= '0;
         vsync_q_reg <= 1'b0;
      end else begin
         if (do_accept)                  cfg_pending <= 1'b1;
         else if (do_apply || do_reload) cfg_pending <= 1'b0;
         if (do_accept)      cfg_err <= 1'b0;
         else if (do_reject) cfg_err <= 1'b1;
         wd_reg      <= (state_reg == ST_ARMED) ? wd_reg + {{(TIMEOUT_W-1){1'b0}}, 1'b1} : '0;
         vsync_q_reg <= vsync;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hsync_q_reg  <= 1'b0;
         line_cnt_reg <= 12'd0;
         line_len     <= 12'd0;
      end else begin
         hsync_q_reg <= hsync;
         if (hs_rise) begin
            line_len     <= line_inc;
            line_cnt_reg <= 12'd0;
         end else begin
            line_cnt_reg <= line_inc;
         end
      end
   end

endmodule

// File: doc/yc_cfg_sched.md
Name: yc_cfg_sched

Overview:
- Configuration scheduler for the luma/chroma encoder.
- Holds shadow copies of the subcarrier phase increment, the PAL enable and the colorburst window, and validates them on a commit request.
- Transfers them to the encoder's PHASE_INC, PAL_EN and COLORBURST_RANGE inputs only at a frame boundary (vsync rising edge), so a standard or timing change never tears a field.
- Also measures line length in clocks for software readback.

Parameters:
- DEF_PHASE_INC, 40'd78715011372, reset value of phase_inc (NTSC subcarrier at 50 MHz clk).
- DEF_PAL_EN, 1'b0, reset value of pal_en.
- DEF_CB_RANGE, 27'd42189040, reset value of colorburst_range ({7'd40, 10'd240, 10'd240}).
- TIMEOUT_W, 22, width of the armed-state watchdog; forced apply after 2^TIMEOUT_W clocks.

Ports:
- clk, in, 1, single clock.
- reset_n, in, 1, reset, asynchronous, active-low.
- cfg_wr, in, 1, write strobe; a write takes effect when cfg_wr && cfg_ready.
- cfg_addr, in, 2, register select.
- cfg_wdata, in, 32, write data.
- cfg_ready, out, 1, write acceptance (combinational from state and cfg_addr).
- hsync, in, 1, active-high horizontal sync.
- vsync, in, 1, active-high vertical sync.
- phase_inc, out, 40, active phase increment.
- pal_en, out, 1, active PAL select.
- colorburst_range, out, 27, active burst window: [26:20] start, [19:10] NTSC end, [9:0] PAL end.
- cfg_pending, out, 1, commit armed and not yet applied.
- cfg_err, out, 1, sticky: last commit rejected.
- line_len, out, 12, clocks between the last two hsync rising edges, saturating.

Behaviour:
- Reset (reset_n low, async):
  - phase_inc=DEF_PHASE_INC, pal_en=DEF_PAL_EN, colorburst_range=DEF_CB_RANGE.
  - Shadows are loaded with the same defaults.
  - cfg_pending=0, cfg_err=0, line_len=0, state=IDLE, watchdog=0, edge-detect registers=0.
- Register map (writes only):
  - addr0: shadow phase_inc[31:0] = wdata.
  - addr1: shadow phase_inc[39:32] = wdata[7:0]; shadow pal_en = wdata[8].
  - addr2: shadow colorburst_range = wdata[26:0].
  - addr3: command. wdata[0]=commit, wdata[1]=abort; abort wins if both are set.
- cfg_ready = (state==IDLE) || (cfg_addr==3). Shadow writes while ARMED or APPLY are stalled, never dropped silently.
- Validation on commit: valid iff start < end and end <= 10'd1023. The end field is [9:0] when shadow pal_en=1, else [19:10].
  - Invalid: cfg_err<=1, state stays IDLE, outputs unchanged.
  - Valid: cfg_err<=0, state<=ARMED, cfg_pending<=1.
- States:
  - IDLE: accepts shadow writes and commit; abort reloads shadows from active values.
  - ARMED:
    - vs_rise = vsync && !vsync_q, where vsync_q is registered every cycle.
    - vs_rise -> APPLY.
    - Watchdog counts every ARMED cycle; at all-ones -> APPLY.
    - Abort -> IDLE, cfg_pending<=0, shadows reloaded from active.
    - Commit while ARMED is ignored.
  - APPLY (1 cycle): active outputs <= shadows (all fields in the same cycle); cfg_pending<=0; watchdog<=0; -> IDLE.
- Latency: vs_rise in cycle n (ARMED) -> APPLY in n+1 -> new outputs visible in n+2.
- A vsync already high, or rising, in the same cycle as the commit does not apply. The first vs_rise strictly after the ARMED entry does.
- Abort and vs_rise in the same ARMED cycle: abort wins, and no apply occurs.
- line_len:
  - Counter increments every clk and saturates at 4095.
  - On hsync rising edge: line_len<=counter value+1 (saturated), counter<=0.
  - Unaffected by the state machine.
- No output other than cfg_ready is combinational.

Test Plan:
- Reset, no writes -> phase_inc=78715011372, pal_en=0, colorburst_range=42189040, cfg_pending=0, cfg_err=0.
- Write addr0=32'h1234_5678, addr1=32'h0000_01AB, commit; vsync rises 100 clocks later:
  - cfg_pending=1 until then.
  - phase_inc=40'hAB_1234_5678 and pal_en=1 exactly 2 clocks after the rising edge.
  - cfg_pending=0 on that same cycle.
- Write addr2={7'd50, 10'd240, 10'd40} with pal_en=1, commit -> cfg_err=1, no ARMED, outputs unchanged. Then write pal_en=0 and commit -> accepted, cfg_err=0.
- ARMED, drive cfg_wr addr0 -> cfg_ready=0 until apply. Abort in the same cycle as vs_rise -> no update, cfg_pending=0, shadows equal active values.
- ARMED with vsync held low, TIMEOUT_W=4 -> apply after 16 ARMED clocks.
- hsync rising edges 858 clocks apart -> line_len=858. With no hsync for 5000 clocks, the next edge -> line_len=4095. Assert reset_n mid-ARMED -> all defaults immediately.
